// File: rtl/ext_mem_responder.sv
// Fixed-latency flop-RAM responder for a regblock external-block port.
// Optional EXT_MEM_STALL_EN adds an ack_stall input that holds the FSM in ACK.
module ext_mem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef EXT_MEM_STALL_EN
  input  logic                  ack_stall,
`endif
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_biten,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ack,
  output logic                  wr_ack,
  output logic                  busy,
  output logic                  overlap_err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [3:0] LAT_M1 = 4'(ACK_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state_q, state_nxt;
  logic [3:0]            cnt_q, cnt_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic                  is_wr_q;
  logic [DATA_WIDTH-1:0] data_q, biten_q, rd_data_q;
  logic                  ovl_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  stall;
  logic                  accept, ovl_set, commit;
  logic [IDX_W-1:0]      nxt_idx;
  logic                  nxt_is_wr;
  logic [DATA_WIDTH-1:0] merged, rd_word;

`ifdef EXT_MEM_STALL_EN
  assign stall = ack_stall;
`else
  assign stall = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;
    ovl_set   = 1'b0;
    unique case (state_q)
      S_IDLE: accept = req;
      S_WAIT: begin
        ovl_set = req;
        cnt_nxt = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (stall)    ovl_set   = req;
        else if (req) accept    = 1'b1;
        else          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (accept) begin
      cnt_nxt   = LAT_M1;
      state_nxt = (ACK_LATENCY == 1) ? S_ACK : S_WAIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign commit    = (state_q == S_ACK) && is_wr_q && !stall;
  assign nxt_idx   = accept ? addr[ADDR_WIDTH-1:2] : idx_q;
  assign nxt_is_wr = accept ? req_is_wr : is_wr_q;
  assign merged    = (mem[idx_q] & ~biten_q) | (data_q & biten_q);
  // A read entering ACK on the same edge as a commit must see the merged word.
  assign rd_word   = (commit && (idx_q == nxt_idx)) ? merged : mem[nxt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      is_wr_q   <= 1'b0;
      data_q    <= '0;
      biten_q   <= '0;
      rd_data_q <= '0;
      ovl_q     <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= addr[ADDR_WIDTH-1:2];
        is_wr_q <= req_is_wr;
        data_q  <= wr_data;
        biten_q <= wr_biten;
      end
      rd_data_q <= (state_nxt == S_ACK && !nxt_is_wr) ? rd_word : '0;
      if (ovl_set) ovl_q <= 1'b1;
    end
  end

  // NOTE: the storage is cleared by reset because a read after reset must return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx_q] <= merged;
    end
  end

  assign rd_ack      = (state_q == S_ACK) && !is_wr_q && !stall;
  assign wr_ack      = commit;
  assign busy        = (state_q != S_IDLE);
  assign overlap_err = ovl_q;
`ifdef EXT_MEM_STALL_EN
  assign rd_data     = rd_ack ? rd_data_q : '0;
`else
  assign rd_data     = rd_data_q;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: three instances (latency 2, 1, 3) share one stimulus
// stream and are compared every cycle against a per-instance access/due-cycle model.
module tb_ext_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, req_is_wr;
  logic [5:0]  addr;
  logic [31:0] wr_data, wr_biten;

  logic [31:0] rd_data [3];
  logic        rd_ack [3], wr_ack [3], busy [3], overlap_err [3];

  ext_mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .ACK_LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .req_is_wr(req_is_wr), .addr(addr),
    .wr_data(wr_data), .wr_biten(wr_biten), .rd_data(rd_data[0]), .rd_ack(rd_ack[0]),
    .wr_ack(wr_ack[0]), .busy(busy[0]), .overlap_err(overlap_err[0]));
  ext_mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .ACK_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .req_is_wr(req_is_wr), .addr(addr),
    .wr_data(wr_data), .wr_biten(wr_biten), .rd_data(rd_data[1]), .rd_ack(rd_ack[1]),
    .wr_ack(wr_ack[1]), .busy(busy[1]), .overlap_err(overlap_err[1]));
  ext_mem_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .ACK_LATENCY(3)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .req_is_wr(req_is_wr), .addr(addr),
    .wr_data(wr_data), .wr_biten(wr_biten), .rd_data(rd_data[2]), .rd_ack(rd_ack[2]),
    .wr_ack(wr_ack[2]), .busy(busy[2]), .overlap_err(overlap_err[2]));

  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 3;
  endfunction

  // Model: each instance holds at most one access, due (acked) in a known cycle.
  int          cyc;
  bit          m_pend [3];
  int          m_due [3];
  bit          m_wr [3];
  int          m_idx [3];
  logic [31:0] m_data [3], m_biten [3];
  logic [31:0] m_mem [3][16];
  bit          m_ovl [3];

  int          n_checks, n_errors;
  int          ack_cnt [3];
  logic [31:0] last_rd0;
  int          req_cyc0, ack_delay0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit q, input bit w, input logic [5:0] a,
                      input logic [31:0] d, input logic [31:0] b);
    bit          e_rd, e_wr;
    logic [31:0] e_data;
    @(negedge clk);
    rst = r; req = q; req_is_wr = w; addr = a; wr_data = d; wr_biten = b;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_pend[k] = 0;
        m_ovl[k]  = 0;
        for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      end else begin
        if (m_pend[k] && m_due[k] == cyc) begin
          if (m_wr[k])
            m_mem[k][m_idx[k]] = (m_mem[k][m_idx[k]] & ~m_biten[k]) | (m_data[k] & m_biten[k]);
          m_pend[k] = 0;
        end
        if (q) begin
          if (!m_pend[k]) begin
            m_pend[k] = 1; m_due[k] = cyc + lat(k); m_wr[k] = w;
            m_idx[k] = int'(a) / 4; m_data[k] = d; m_biten[k] = b;
            if (k == 0) req_cyc0 = cyc;
          end else begin
            m_ovl[k] = 1;
          end
        end
      end
    end
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      e_rd   = m_pend[k] && (m_due[k] == cyc) && !m_wr[k];
      e_wr   = m_pend[k] && (m_due[k] == cyc) && m_wr[k];
      e_data = e_rd ? m_mem[k][m_idx[k]] : 32'h0;
      check($sformatf("rd_ack%0d", k), {31'b0, rd_ack[k]}, {31'b0, e_rd});
      check($sformatf("wr_ack%0d", k), {31'b0, wr_ack[k]}, {31'b0, e_wr});
      check($sformatf("rd_data%0d", k), rd_data[k], e_data);
      check($sformatf("busy%0d", k), {31'b0, busy[k]}, {31'b0, m_pend[k]});
      check($sformatf("overlap_err%0d", k), {31'b0, overlap_err[k]}, {31'b0, m_ovl[k]});
      if (rd_ack[k] === 1'b1 || wr_ack[k] === 1'b1) ack_cnt[k]++;
    end
    if (rd_ack[0] === 1'b1) last_rd0 = rd_data[0];
    if (rd_ack[0] === 1'b1 || wr_ack[0] === 1'b1) ack_delay0 = cyc - req_cyc0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 6'($urandom), $urandom, $urandom);
  endtask

  task automatic rd(input logic [5:0] a);
    step(0, 1, 0, a, $urandom, $urandom);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [31:0] b);
    step(0, 1, 1, a, d, b);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0; last_rd0 = 32'hFFFF_FFFF;
    req_cyc0 = 0; ack_delay0 = -1;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_ovl[k] = 0; ack_cnt[k] = 0; m_due[k] = 0;
      m_wr[k] = 0; m_idx[k] = 0; m_data[k] = '0; m_biten[k] = '0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
    end
    rst = 1; req = 0; req_is_wr = 0; addr = '0; wr_data = '0; wr_biten = '0;

    // Reset, then a read of 0x04 acked exactly two cycles later with zero data.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    rd(6'h04);
    idle(4);
    check("t1_delay", 32'(ack_delay0), 32'd2);
    check("t1_data", last_rd0, 32'h0);

    // Full write then partial byte write, read back the merge.
    wr(6'h08, 32'hDEADBEEF, 32'hFFFFFFFF);
    idle(4);
    wr(6'h08, 32'h12345678, 32'h0000FF00);
    idle(4);
    rd(6'h08);
    idle(4);
    check("t2_merge", last_rd0, 32'hDEAD56EF);

    // Back-to-back traffic: latency-1 instance accepts every request.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    for (int i = 0; i < 8; i++) wr(6'(i * 4), 32'hA5000000 + 32'(i * 32'h111), 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) rd(6'(i * 4));
    idle(4);
    check("t3_acks", 32'(ack_cnt[1]), 32'd16);
    check("t3_no_ovl", {31'b0, overlap_err[1]}, 32'd0);

    // Request while busy on the latency-3 instance: ignored, sticky error.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    wr(6'h10, 32'h0BADF00D, 32'hFFFFFFFF);
    rd(6'h14);
    idle(5);
    check("t4_one_ack", 32'(ack_cnt[2]), 32'd1);
    idle(3);
    check("t4_sticky", {31'b0, overlap_err[2]}, 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("t4_cleared", {31'b0, overlap_err[2]}, 32'd0);

    // Reset one cycle before the ack drops the pending write.
    for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    wr(6'h3C, 32'hCAFEBABE, 32'hFFFFFFFF);
    step(1, 0, 0, 0, 0, 0);
    check("t5_no_ack", 32'(ack_cnt[0]), 32'd0);
    last_rd0 = 32'hFFFF_FFFF;
    rd(6'h3C);
    idle(4);
    check("t5_data", last_rd0, 32'h0);

    // Randomized traffic including zero/partial bit enables and occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1), 6'($urandom), $urandom, b);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
